mar_seq: RTL and testbench

Parametrised memory address register with a burst address sequencer; next generation of the 4-bit, gated-load MAR in the TinyTapeout top. Holds an AW-bit address that is loaded, incremented or decremented under the g1/g2 dual-enable, with optional bounded wrap. Can also stream an N-beat address burst to a downstream memory port over a valid/ready handshake. Sits between the top-level pin decode (ui_in/uio_in) and the memory/output mux.

---
 rtl/mar_seq_pkg.sv | 15 +
 rtl/mar_step.sv | 34 +++
 rtl/mar_seq.sv | 117 +++++++++++
 tb/tb_mar_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mar_seq_pkg.sv
// Shared encodings for the mar_seq address register and burst sequencer.
// The build macro MAR_SEQ_WRAP_EN (used in mar_step) enables bounded window wrap.
package mar_seq_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_INC  = 2'b10;
  localparam logic [1:0] SEL_DEC  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/mar_step.sv
// Combinational next-address step for mar_seq, shared by single steps and bursts.
// With MAR_SEQ_WRAP_EN defined, stepping off a window bound wraps to the other bound.
module mar_step #(
  parameter int unsigned AW = 8
) (
  input  logic [AW-1:0] addr,
  input  logic          dir,
  input  logic [AW-1:0] lo,
  input  logic [AW-1:0] hi,
  output logic [AW-1:0] next,
  output logic          wrapped
);

  // dir=0 steps up, dir=1 steps down; bound hits are equality-only
  always_comb begin
    next    = dir ? (addr - AW'(1)) : (addr + AW'(1));
    wrapped = 1'b0;
`ifdef MAR_SEQ_WRAP_EN
    if (!dir && (addr == hi)) begin
      next    = lo;
      wrapped = 1'b1;
    end else if (dir && (addr == lo)) begin
      next    = hi;
      wrapped = 1'b1;
    end
`endif
  end

`ifndef MAR_SEQ_WRAP_EN
  logic unused_bounds;
  assign unused_bounds = ^{lo, hi};
`endif

endmodule

// File: rtl/mar_seq.sv
// Memory address register with gated load/inc/dec and a valid/ready address burst sequencer.
// Window wrap is enabled by defining MAR_SEQ_WRAP_EN.
module mar_seq
  import mar_seq_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned LW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          g1,
  input  logic          g2,
  input  logic [1:0]    select,
  input  logic [AW-1:0] d_in,
  input  logic [AW-1:0] lo_bound,
  input  logic [AW-1:0] hi_bound,
  input  logic          burst_start,
  input  logic [LW-1:0] burst_len,
  input  logic          burst_dir,
  input  logic          addr_ready,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  output logic          busy,
  output logic          wrap,
  output logic          done
);

  state_t        state, state_nx;
  logic [LW-1:0] cnt, cnt_nx;
  logic          dir_q, dir_nx;
  logic [AW-1:0] addr_nx;
  logic          wrap_nx, done_nx;
  logic          en;
  logic          step_dir;
  logic [AW-1:0] step_next;
  logic          step_wrap;

  assign en = g1 & g2;

  // In IDLE select[0] distinguishes inc (0) from dec (1); in BURST the latched direction rules
  assign step_dir = (state == BURST) ? dir_q : select[0];

  mar_step #(.AW(AW)) u_step (
    .addr    (addr_out),
    .dir     (step_dir),
    .lo      (lo_bound),
    .hi      (hi_bound),
    .next    (step_next),
    .wrapped (step_wrap)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dir_nx   = dir_q;
    addr_nx  = addr_out;
    wrap_nx  = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          if (burst_start) begin
            state_nx = BURST;
            cnt_nx   = burst_len;
            dir_nx   = burst_dir;
          end else begin
            case (select)
              SEL_HOLD: ;
              SEL_LOAD: addr_nx = d_in;
              SEL_INC, SEL_DEC: begin
                addr_nx = step_next;
                wrap_nx = step_wrap;
              end
            endcase
          end
        end
      end
      BURST: begin
        // Address only advances on a handshake; the final one leaves it one past the last beat
        if (addr_ready) begin
          addr_nx = step_next;
          wrap_nx = step_wrap;
          if (cnt == '0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt - LW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= '0;
      dir_q      <= 1'b0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      wrap       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      dir_q      <= dir_nx;
      addr_out   <= addr_nx;
      addr_valid <= (state_nx == BURST);
      busy       <= (state_nx == BURST);
      wrap       <= wrap_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_mar_seq.sv
// Randomized plus directed bench for mar_seq against a beat-counting reference model.
// Honours MAR_SEQ_WRAP_EN the same way the design does.
module tb_mar_seq;

  localparam int unsigned AW = 8;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          g1, g2;
  logic [1:0]    select;
  logic [AW-1:0] d_in, lo_bound, hi_bound;
  logic          burst_start;
  logic [LW-1:0] burst_len;
  logic          burst_dir;
  logic          addr_ready;
  logic [AW-1:0] addr_out;
  logic          addr_valid, busy, wrap, done;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_addr;
  bit m_busy;
  int m_left;
  bit m_dir;

  // DUT-observed activity
  int dut_hs = 0;
  int dut_done = 0;
  int beat_q[$];

  mar_seq #(.AW(AW), .LW(LW)) dut (
    .clk         (clk),
    .clr         (clr),
    .g1          (g1),
    .g2          (g2),
    .select      (select),
    .d_in        (d_in),
    .lo_bound    (lo_bound),
    .hi_bound    (hi_bound),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .burst_dir   (burst_dir),
    .addr_ready  (addr_ready),
    .addr_out    (addr_out),
    .addr_valid  (addr_valid),
    .busy        (busy),
    .wrap        (wrap),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mstep(input int a, input bit dec, output bit w);
    w = 1'b0;
`ifdef MAR_SEQ_WRAP_EN
    if (!dec && a == int'(hi_bound)) begin w = 1'b1; return int'(lo_bound); end
    if (dec && a == int'(lo_bound)) begin w = 1'b1; return int'(hi_bound); end
`endif
    return dec ? (a + 255) % 256 : (a + 1) % 256;
  endfunction

  task automatic m_reset();
    m_addr = 0;
    m_busy = 1'b0;
    m_left = 0;
    m_dir  = 1'b0;
  endtask

  // One clock: model consumes the inputs seen at the edge, then outputs are compared
  task automatic tick();
    bit exp_wrap, exp_done, w;
    if (addr_valid && addr_ready) begin
      dut_hs++;
      beat_q.push_back(int'(addr_out));
    end
    @(posedge clk);
    exp_wrap = 1'b0;
    exp_done = 1'b0;
    if (m_busy) begin
      if (addr_ready) begin
        m_addr   = mstep(m_addr, m_dir, w);
        exp_wrap = w;
        m_left--;
        if (m_left == 0) begin
          m_busy   = 1'b0;
          exp_done = 1'b1;
        end
      end
    end else if (g1 && g2) begin
      if (burst_start) begin
        m_busy = 1'b1;
        m_left = int'(burst_len) + 1;
        m_dir  = burst_dir;
      end else if (select == 2'd1) begin
        m_addr = int'(d_in);
      end else if (select != 2'd0) begin
        m_addr   = mstep(m_addr, select[0], w);
        exp_wrap = w;
      end
    end
    #1;
    if (done) dut_done++;
    check("addr",  32'(addr_out),   32'(m_addr));
    check("valid", 32'(addr_valid), 32'(m_busy));
    check("busy",  32'(busy),       32'(m_busy));
    check("wrap",  32'(wrap),       32'(exp_wrap));
    check("done",  32'(done),       32'(exp_done));
  endtask

  task automatic load(input logic [AW-1:0] v);
    g1 = 1'b1; g2 = 1'b1; burst_start = 1'b0; select = 2'd1; d_in = v;
    tick();
    select = 2'd0;
  endtask

  task automatic start_burst(input logic [LW-1:0] len, input logic dir);
    g1 = 1'b1; g2 = 1'b1; burst_start = 1'b1; burst_len = len; burst_dir = dir;
    addr_ready = 1'b0;
    tick();
    burst_start = 1'b0;
    beat_q.delete();
  endtask

  // toggle=1 drives ready as 1,0,0,1,0,0,...; budget bounds the wait for done
  task automatic run_burst(input bit toggle, input int budget, output int cycles);
    int d0 = dut_done;
    cycles = 0;
    while (cycles < budget && dut_done == d0) begin
      addr_ready = toggle ? (cycles % 3 == 0) : 1'b1;
      tick();
      cycles++;
    end
    addr_ready = 1'b0;
    check("burst_done_cnt", 32'(dut_done - d0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, h0;
    clr = 1'b1; g1 = 1'b0; g2 = 1'b0; select = 2'd0; d_in = '0;
    lo_bound = 8'h00; hi_bound = 8'hFF; burst_start = 1'b0; burst_len = '0;
    burst_dir = 1'b0; addr_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",  32'(addr_out),   32'd0);
    check("rst_valid", 32'(addr_valid), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_wrap",  32'(wrap),       32'd0);
    check("rst_done",  32'(done),       32'd0);
    clr = 1'b0;

    // load, then gated increment
    load(8'h3C);
    check("load_3c", 32'(addr_out), 32'h3C);
    g2 = 1'b0; select = 2'd2;
    tick();
    check("gated_inc", 32'(addr_out), 32'h3C);
    g2 = 1'b1; select = 2'd0;

    // window wrap
    lo_bound = 8'h10; hi_bound = 8'h13;
    load(8'h13);
    select = 2'd2; tick();
`ifdef MAR_SEQ_WRAP_EN
    check("inc_wrap_addr", 32'(addr_out), 32'h10);
    check("inc_wrap_flag", 32'(wrap), 32'd1);
`else
    check("inc_wrap_addr", 32'(addr_out), 32'h14);
    check("inc_wrap_flag", 32'(wrap), 32'd0);
`endif
    select = 2'd0; tick();
    check("wrap_one_cycle", 32'(wrap), 32'd0);
    select = 2'd3; tick();
    check("dec_addr", 32'(addr_out), 32'h13);
    load(8'hFF);
    select = 2'd2; tick();
    check("inc_ff_addr", 32'(addr_out), 32'h00);
    check("inc_ff_wrap", 32'(wrap), 32'd0);
    select = 2'd0;
    lo_bound = 8'h00; hi_bound = 8'hFF;

    // ascending burst with ready held high
    load(8'h20);
    start_burst(4'd3, 1'b0);
    check("burst_first", 32'(addr_out), 32'h20);
    h0 = dut_hs;
    run_burst(1'b0, 20, n);
    check("burst_cycles", 32'(n), 32'd4);
    check("burst_hs", 32'(dut_hs - h0), 32'd4);
    for (int i = 0; i < 4; i++)
      check("burst_beat", 32'(beat_q.size() > i ? beat_q[i] : -1), 32'(32'h20 + i));
    check("burst_end_addr", 32'(addr_out), 32'h24);
    check("burst_end_busy", 32'(busy), 32'd0);

    // same burst with stalled ready
    load(8'h20);
    start_burst(4'd3, 1'b0);
    h0 = dut_hs;
    run_burst(1'b1, 40, n);
    check("stall_hs", 32'(dut_hs - h0), 32'd4);
    check("stall_cycles", 32'(n), 32'd10);
    check("stall_end_addr", 32'(addr_out), 32'h24);

    // burst_start beats a same-cycle load; load during burst ignored
    load(8'h40);
    select = 2'd1; d_in = 8'h99;
    start_burst(4'd1, 1'b0);
    check("start_vs_load", 32'(addr_out), 32'h40);
    run_burst(1'b0, 10, n);
    check("load_in_burst", 32'(addr_out), 32'h42);
    select = 2'd0;

    // clr mid-burst after second beat
    load(8'h50);
    start_burst(4'd5, 1'b0);
    addr_ready = 1'b1;
    tick(); tick();
    h0 = dut_done;
    #2 clr = 1'b1;
    #1;
    check("clr_addr",  32'(addr_out),   32'd0);
    check("clr_valid", 32'(addr_valid), 32'd0);
    check("clr_busy",  32'(busy),       32'd0);
    m_reset();
    @(posedge clk);
    #1;
    check("clr_no_done", 32'(done), 32'd0);
    clr = 1'b0; addr_ready = 1'b0;
    tick();
    check("clr_done_cnt", 32'(dut_done - h0), 32'd0);

    // single-beat burst
    load(8'h70);
    start_burst(4'd0, 1'b1);
    h0 = dut_hs;
    run_burst(1'b0, 10, n);
    check("len0_cycles", 32'(n), 32'd1);
    check("len0_hs", 32'(dut_hs - h0), 32'd1);
    check("len0_addr", 32'(addr_out), 32'h6F);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      g1 = ($urandom % 8) != 0;
      g2 = ($urandom % 8) != 0;
      select = 2'($urandom);
      d_in = 8'($urandom);
      burst_start = ($urandom % 6) == 0;
      burst_len = 4'($urandom);
      burst_dir = 1'($urandom);
      addr_ready = ($urandom % 10) < 7;
      if ($urandom % 50 == 0) begin
        lo_bound = 8'($urandom);
        hi_bound = 8'(lo_bound + 8'($urandom_range(0, 7)));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
